// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: multi-lane control-flow resolver.
//  - Resolves up to N_LANES branches/jumps per cycle against their prediction.
//  - Registers one redirect per captured group (oldest mispredicting lane wins).
//  - Pushes resolved outcomes into a handshaked FIFO toward the BTB/BHT updater.
//  - Keeps saturating mispredict and drop counters.
// Optional feature macro: BRANCH_LIKELY_EN (branch-likely ops + redirect_nullify_o).
`timescale 1ns/1ps

package branch_resolve_pkg;

  typedef enum logic [4:0] {
    OP_NOP, OP_ALU,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    OP_JAL, OP_JALR,
    OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL, OP_BLTZL, OP_BGEZL
  } op_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic        is_controlflow;
    logic [31:0] default_jump_i;  // conditional-branch target
    logic [31:0] default_jump_j;  // JAL target
  } pipe_id_t;

  function automatic logic is_likely_op(input op_t op);
    return op inside {OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL, OP_BLTZL, OP_BGEZL};
  endfunction

endpackage

module branch_resolve_unit
  import branch_resolve_pkg::*;
#(
  parameter int  N_LANES   = 2,
  parameter int  UPD_DEPTH = 8,
  parameter int  CNT_WIDTH = 16,
  localparam int LANE_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  pipe_id_t             pipe_id_i     [N_LANES],
  input  logic [31:0]          reg0_i        [N_LANES],
  input  logic [31:0]          reg1_i        [N_LANES],
  input  logic [31:0]          pc_i          [N_LANES],
  input  logic [N_LANES-1:0]   pred_taken_i,
  input  logic [31:0]          pred_target_i [N_LANES],
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic [LANE_W-1:0]    redirect_lane_o,
  output logic [N_LANES-1:0]   kill_mask_o,
`ifdef BRANCH_LIKELY_EN
  output logic                 redirect_nullify_o,
`endif
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [31:0]          upd_pc_o,
  output logic                 upd_taken_o,
  output logic [31:0]          upd_target_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int AW = $clog2(UPD_DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit separates full from empty

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  // ---------------------------------------------------------------------------
  // Per-lane resolution
  // ---------------------------------------------------------------------------
  logic [N_LANES-1:0] lane_eq, lane_res, lane_taken, lane_mis, lane_redir;
  logic [31:0]        lane_target  [N_LANES];
  logic [31:0]        lane_next_pc [N_LANES];
`ifdef BRANCH_LIKELY_EN
  logic [N_LANES-1:0] lane_likely_nt;
`endif

  // Direction, target, mispredict and correct next PC for every lane in parallel.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      lane_eq[l]     = (reg0_i[l] == reg1_i[l]);
      lane_taken[l]  = 1'b0;
      lane_target[l] = pipe_id_i[l].default_jump_i;
      case (pipe_id_i[l].op)
        OP_BLTZ, OP_BLTZAL: lane_taken[l] = reg1_i[l][31];
        OP_BGEZ, OP_BGEZAL: lane_taken[l] = ~reg1_i[l][31];
        OP_BEQ:             lane_taken[l] = lane_eq[l];
        OP_BNE:             lane_taken[l] = ~lane_eq[l];
        OP_BLEZ:            lane_taken[l] = lane_eq[l] | reg1_i[l][31];
        OP_BGTZ:            lane_taken[l] = ~lane_eq[l] & ~reg1_i[l][31];
        OP_JAL: begin
          lane_taken[l]  = 1'b1;
          lane_target[l] = pipe_id_i[l].default_jump_j;
        end
        OP_JALR: begin
          lane_taken[l]  = 1'b1;
          lane_target[l] = reg0_i[l];
        end
`ifdef BRANCH_LIKELY_EN
        OP_BLTZL:           lane_taken[l] = reg1_i[l][31];
        OP_BGEZL:           lane_taken[l] = ~reg1_i[l][31];
        OP_BEQL:            lane_taken[l] = lane_eq[l];
        OP_BNEL:            lane_taken[l] = ~lane_eq[l];
        OP_BLEZL:           lane_taken[l] = lane_eq[l] | reg1_i[l][31];
        OP_BGTZL:           lane_taken[l] = ~lane_eq[l] & ~reg1_i[l][31];
`endif
        default:            lane_taken[l] = 1'b0;
      endcase

      lane_res[l] = pipe_id_i[l].valid & pipe_id_i[l].is_controlflow;
      lane_mis[l] = lane_res[l] &
                    ((lane_taken[l] != pred_taken_i[l]) |
                     (lane_taken[l] & (lane_target[l] != pred_target_i[l])));
`ifdef BRANCH_LIKELY_EN
      // A not-taken likely branch must always redirect to squash its delay slot.
      lane_likely_nt[l] = lane_res[l] & is_likely_op(pipe_id_i[l].op) & ~lane_taken[l];
      lane_redir[l]     = lane_mis[l] | lane_likely_nt[l];
`else
      // Without the feature, likely ops resolve not-taken and never redirect.
      lane_redir[l]     = lane_mis[l] & ~is_likely_op(pipe_id_i[l].op);
`endif
      // Not-taken resumes after the delay slot; 32-bit wrap is intended.
      lane_next_pc[l] = lane_taken[l] ? lane_target[l] : pc_i[l] + 32'd8;
    end
  end

  // ---------------------------------------------------------------------------
  // Oldest-lane redirect selection and kill mask
  // ---------------------------------------------------------------------------
  logic               sel_found;
  logic [LANE_W-1:0]  sel_lane;
  logic [31:0]        sel_pc;
  logic [N_LANES-1:0] sel_kill, push_mask;
`ifdef BRANCH_LIKELY_EN
  logic               sel_likely_nt;
`endif

  // Scan youngest to oldest so the lowest-index redirecting lane wins; the
  // delay-slot lane of a likely branch is always above it, so it is covered.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    sel_pc    = '0;
`ifdef BRANCH_LIKELY_EN
    sel_likely_nt = 1'b0;
`endif
    for (int l = N_LANES - 1; l >= 0; l--) begin
      if (lane_redir[l]) begin
        sel_found = 1'b1;
        sel_lane  = LANE_W'(l);
        sel_pc    = lane_next_pc[l];
`ifdef BRANCH_LIKELY_EN
        sel_likely_nt = lane_likely_nt[l];
`endif
      end
    end
    for (int l = 0; l < N_LANES; l++) begin
      sel_kill[l] = sel_found && (l > int'(sel_lane));
    end
    push_mask = lane_res & ~sel_kill;
  end

  logic capture;
  assign capture = ~stall_i & ~flush_i;

  // ---------------------------------------------------------------------------
  // Redirect stage register
  // ---------------------------------------------------------------------------
  // Flush clears, stall holds target info but drops the one-shot valid/kill.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_o   <= 1'b0;
      redirect_pc_o      <= '0;
      redirect_lane_o    <= '0;
      kill_mask_o        <= '0;
`ifdef BRANCH_LIKELY_EN
      redirect_nullify_o <= 1'b0;
`endif
    end else if (flush_i) begin
      redirect_valid_o   <= 1'b0;
      redirect_pc_o      <= '0;
      redirect_lane_o    <= '0;
      kill_mask_o        <= '0;
`ifdef BRANCH_LIKELY_EN
      redirect_nullify_o <= 1'b0;
`endif
    end else if (!stall_i) begin
      redirect_valid_o   <= sel_found;
      redirect_pc_o      <= sel_pc;
      redirect_lane_o    <= sel_lane;
      kill_mask_o        <= sel_kill;
`ifdef BRANCH_LIKELY_EN
      redirect_nullify_o <= sel_found & sel_likely_nt &
                            (sel_lane == LANE_W'(N_LANES - 1));
`endif
    end else begin
      redirect_valid_o   <= 1'b0;
      kill_mask_o        <= '0;
`ifdef BRANCH_LIKELY_EN
      redirect_nullify_o <= 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Predictor-update FIFO
  // ---------------------------------------------------------------------------
  upd_t               mem [UPD_DEPTH];
  upd_t               head;
  logic [PW-1:0]      wr_ptr, rd_ptr, used;
  logic [PW:0]        free_slots;
  logic [PW-1:0]      slot [N_LANES];
  logic [N_LANES-1:0] write_en;
  logic [PW-1:0]      n_push, n_write, n_drop;
  logic               fifo_empty, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign pop        = ~fifo_empty & upd_ready_i;

  // Assign each pushing lane its write offset; a same-cycle pop frees one slot.
  always_comb begin
    used       = wr_ptr - rd_ptr;
    free_slots = (PW+1)'(UPD_DEPTH) - {1'b0, used} + (PW+1)'(pop);
    n_push     = '0;
    n_write    = '0;
    for (int l = 0; l < N_LANES; l++) begin
      slot[l]     = n_push;
      write_en[l] = capture & push_mask[l] & ({1'b0, n_push} < free_slots);
      if (capture & push_mask[l]) n_push = n_push + 1'b1;
      if (write_en[l])            n_write = n_write + 1'b1;
    end
    n_drop = n_push - n_write;
  end

  // Pointer advance by accepted pushes and by the pop handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_write;
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end

  // Entry storage write, in lane order.
  // NOTE: storage is deliberately not reset; entries only become visible through the pointers, which are.
  always_ff @(posedge clk) begin
    for (int l = 0; l < N_LANES; l++) begin
      if (write_en[l]) begin
        mem[AW'(wr_ptr + slot[l])] <= '{pc: pc_i[l], taken: lane_taken[l], target: lane_target[l]};
      end
    end
  end

  // Head comes straight from storage, forced to zero while empty.
  always_comb begin
    head         = mem[rd_ptr[AW-1:0]];
    upd_valid_o  = ~fifo_empty;
    upd_pc_o     = fifo_empty ? '0 : head.pc;
    upd_taken_o  = fifo_empty ? 1'b0 : head.taken;
    upd_target_o = fifo_empty ? '0 : head.target;
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt_o} + (CNT_WIDTH+1)'(n_drop);

  // Count captured redirects and updates lost to a full FIFO, clamping at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_cnt_o <= '0;
      drop_cnt_o       <= '0;
    end else begin
      if (capture && sel_found && !(&mispredict_cnt_o)) begin
        mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
      end
      drop_cnt_o <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed, table-driven bench for branch_resolve_unit
// (N_LANES=2, UPD_DEPTH=8), plus hand-written stall/flush/full/reset sequences.
`timescale 1ns/1ps

module tb_branch_resolve_unit;
  import branch_resolve_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, ready;
  pipe_id_t    pipe_id [N];
  logic [31:0] reg0 [N], reg1 [N], pc [N], ptg [N];
  logic [N-1:0] pt;
  logic        rv, lane, upd_valid, upd_taken;
  logic [31:0] rpc, upd_pc, upd_target;
  logic [1:0]  kill;
  logic [15:0] mcnt, dcnt;
`ifdef BRANCH_LIKELY_EN
  logic        nullify;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.N_LANES(N), .UPD_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .pipe_id_i        (pipe_id),
    .reg0_i           (reg0),
    .reg1_i           (reg1),
    .pc_i             (pc),
    .pred_taken_i     (pt),
    .pred_target_i    (ptg),
    .redirect_valid_o (rv),
    .redirect_pc_o    (rpc),
    .redirect_lane_o  (lane),
    .kill_mask_o      (kill),
`ifdef BRANCH_LIKELY_EN
    .redirect_nullify_o (nullify),
`endif
    .upd_valid_o      (upd_valid),
    .upd_ready_i      (ready),
    .upd_pc_o         (upd_pc),
    .upd_taken_o      (upd_taken),
    .upd_target_o     (upd_target),
    .mispredict_cnt_o (mcnt),
    .drop_cnt_o       (dcnt)
  );

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [31:0] r0, r1, pc, dji, djj;
    logic        pt;
    logic [31:0] ptg;
  } lane_in_t;

  typedef struct {
    string       name;
    lane_in_t    a, b;
    logic        rv;
    logic [31:0] rpc;
    logic        lane;
    logic [1:0]  kill;
    int          push;
    logic [31:0] fpc;
    logic        ftaken;
  } vec_t;

  vec_t vecs [12];

  function automatic lane_in_t mk(input logic v, input op_t op,
                                  input logic [31:0] r0, input logic [31:0] r1,
                                  input logic [31:0] p, input logic [31:0] dji,
                                  input logic [31:0] djj, input logic ptk,
                                  input logic [31:0] ptgt);
    return '{valid: v, op: op, r0: r0, r1: r1, pc: p, dji: dji, djj: djj, pt: ptk, ptg: ptgt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input lane_in_t x);
    pipe_id[i].valid          = x.valid;
    pipe_id[i].op             = x.op;
    pipe_id[i].is_controlflow = !(x.op inside {OP_NOP, OP_ALU});
    pipe_id[i].default_jump_i = x.dji;
    pipe_id[i].default_jump_j = x.djj;
    reg0[i] = x.r0;
    reg1[i] = x.r1;
    pc[i]   = x.pc;
    pt[i]   = x.pt;
    ptg[i]  = x.ptg;
  endtask

  task automatic drive(input lane_in_t a, input lane_in_t b);
    set_lane(0, a);
    set_lane(1, b);
  endtask

  task automatic drive_idle();
    drive(mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0), mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0));
  endtask

  // Pop everything currently queued (bounded), reporting count and first entry.
  task automatic drain(output int n, output logic [31:0] fpc, output logic ftaken);
    n = 0;
    fpc = '0;
    ftaken = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!upd_valid) break;
      if (n == 0) begin
        fpc = upd_pc;
        ftaken = upd_taken;
      end
      n++;
      ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  initial begin
    int          exp_m;
    int          n, hi;
    logic [31:0] fpc;
    logic        ft;
    logic        beql_taken;
    lane_in_t    mis_a, mis_b;
    logic [31:0] exp_q [$];

`ifdef BRANCH_LIKELY_EN
    beql_taken = 1'b1;
`else
    beql_taken = 1'b0;
`endif
    mis_a = mk(1'b1, OP_BEQ, 5, 5, 32'h400, 32'h1000, 0, 1'b0, 0);
    mis_b = mk(1'b1, OP_JAL, 0, 0, 32'h404, 0, 32'h5000, 1'b1, 32'h5000);

    //           name              lane0  lane1  rv   redirect_pc   lane  kill  push first_pc  first_taken
    vecs[0]  = '{"beq_mis", mis_a, mis_b, 1'b1, 32'h1000, 1'b0, 2'b10, 1, 32'h400, 1'b1};
    vecs[1]  = '{"jalr_lane1",
                 mk(1'b1, OP_BNE, 3, 3, 32'h500, 32'h600, 0, 1'b0, 0),
                 mk(1'b1, OP_JALR, 32'h8000, 0, 32'h504, 0, 0, 1'b1, 32'h7000),
                 1'b1, 32'h8000, 1'b1, 2'b00, 2, 32'h500, 1'b0};
    vecs[2]  = '{"bgez_ok",
                 mk(1'b1, OP_BGEZ, 0, 1, 32'h700, 32'h2000, 0, 1'b1, 32'h2000),
                 mk(1'b1, OP_ALU, 0, 0, 32'h704, 0, 0, 1'b0, 0),
                 1'b0, 32'h0, 1'b0, 2'b00, 1, 32'h700, 1'b1};
    vecs[3]  = '{"bltz_wrap_ok",
                 mk(1'b1, OP_BLTZ, 0, 32'h8000_0000, 32'hFFFF_FFF8, 32'h100, 0, 1'b1, 32'h100),
                 mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0),
                 1'b0, 32'h0, 1'b0, 2'b00, 1, 32'hFFFF_FFF8, 1'b1};
    vecs[4]  = '{"bltz_wrap_mis",
                 mk(1'b1, OP_BLTZ, 0, 0, 32'hFFFF_FFF8, 32'h100, 0, 1'b1, 32'h100),
                 mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0),
                 1'b1, 32'h0, 1'b0, 2'b10, 1, 32'hFFFF_FFF8, 1'b0};
    vecs[5]  = '{"bgtz_bad_target",
                 mk(1'b1, OP_BGTZ, 1, 2, 32'h3000, 32'h3100, 0, 1'b1, 32'h3104),
                 mk(1'b1, OP_BLEZ, 4, 4, 32'h3004, 32'h3200, 0, 1'b1, 32'h3200),
                 1'b1, 32'h3100, 1'b0, 2'b10, 1, 32'h3000, 1'b1};
    vecs[6]  = '{"jal_lane1",
                 mk(1'b1, OP_BLEZ, 0, 32'hFFFF_FFFF, 32'h800, 32'h900, 0, 1'b1, 32'h900),
                 mk(1'b1, OP_JAL, 0, 0, 32'h804, 0, 32'h9000, 1'b0, 0),
                 1'b1, 32'h9000, 1'b1, 2'b00, 2, 32'h800, 1'b1};
    vecs[7]  = '{"bltzal_nt_oldest_wins",
                 mk(1'b1, OP_BLTZAL, 0, 5, 32'h600, 32'hA00, 0, 1'b1, 32'hA00),
                 mk(1'b1, OP_BGEZAL, 0, 0, 32'h604, 32'hB00, 0, 1'b0, 0),
                 1'b1, 32'h608, 1'b0, 2'b10, 1, 32'h600, 1'b0};
    vecs[8]  = '{"al_both_ok",
                 mk(1'b1, OP_BGEZAL, 0, 32'hFFFF_FFFF, 32'hC00, 32'hD00, 0, 1'b0, 0),
                 mk(1'b1, OP_BLTZAL, 0, 32'hFFFF_FFFF, 32'hC04, 32'hE00, 0, 1'b1, 32'hE00),
                 1'b0, 32'h0, 1'b0, 2'b00, 2, 32'hC00, 1'b0};
    vecs[9]  = '{"beql",
                 mk(1'b1, OP_BEQL, 7, 7, 32'hF00, 32'hF80, 0, 1'b1, 32'hF80),
                 mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0),
                 1'b0, 32'h0, 1'b0, 2'b00, 1, 32'hF00, beql_taken};
    vecs[10] = '{"invalid_and_alu",
                 mk(1'b0, OP_BEQ, 5, 5, 32'h900, 32'h1000, 0, 1'b0, 0),
                 mk(1'b1, OP_ALU, 0, 0, 32'h904, 0, 0, 1'b0, 0),
                 1'b0, 32'h0, 1'b0, 2'b00, 0, 32'h0, 1'b0};
    vecs[11] = '{"bne_lane1_only",
                 mk(1'b0, OP_NOP, 0, 0, 0, 0, 0, 1'b0, 0),
                 mk(1'b1, OP_BNE, 1, 2, 32'h1004, 32'h1100, 0, 1'b0, 0),
                 1'b1, 32'h1100, 1'b1, 2'b00, 1, 32'h1004, 1'b1};

    // Reset state.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; ready = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    check("rst_redirect_valid", 32'(rv), 0);
    check("rst_redirect_pc", rpc, 0);
    check("rst_kill", 32'(kill), 0);
    check("rst_upd_valid", 32'(upd_valid), 0);
    check("rst_upd_pc", upd_pc, 0);
    check("rst_mcnt", 32'(mcnt), 0);
    check("rst_dcnt", 32'(dcnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-group vectors.
    exp_m = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b);
      stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].rv) exp_m++;
      check({vecs[i].name, "_rv"}, 32'(rv), 32'(vecs[i].rv));
      if (vecs[i].rv) begin
        check({vecs[i].name, "_rpc"}, rpc, vecs[i].rpc);
        check({vecs[i].name, "_lane"}, 32'(lane), 32'(vecs[i].lane));
      end
      check({vecs[i].name, "_kill"}, 32'(kill), 32'(vecs[i].kill));
      check({vecs[i].name, "_mcnt"}, 32'(mcnt), 32'(exp_m));
      drive_idle();
      stall = 1'b1;
      drain(n, fpc, ft);
      check({vecs[i].name, "_push"}, 32'(n), 32'(vecs[i].push));
      if (vecs[i].push > 0) begin
        check({vecs[i].name, "_first_pc"}, fpc, vecs[i].fpc);
        check({vecs[i].name, "_first_taken"}, 32'(ft), 32'(vecs[i].ftaken));
      end
      stall = 1'b0;
    end
    check("table_dcnt", 32'(dcnt), 0);

    // Stall after a mispredict capture: redirect is a one-cycle pulse.
    drive(mis_a, mis_b);
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    stall = 1'b1;
    hi = int'(rv);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      hi += int'(rv);
    end
    exp_m++;
    check("stall_rv_cycles", 32'(hi), 1);
    check("stall_mcnt", 32'(mcnt), 32'(exp_m));
    drain(n, fpc, ft);
    check("stall_push", 32'(n), 1);
    stall = 1'b0;

    // Flush in the input cycle: nothing captured.
    drive(mis_a, mis_b);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    drive_idle();
    check("flush_rv", 32'(rv), 0);
    check("flush_upd_valid", 32'(upd_valid), 0);
    check("flush_mcnt", 32'(mcnt), 32'(exp_m));

    // Fill past capacity with the updater blocked.
    ready = 1'b0;
    for (int g = 0; g < 5; g++) begin
      drive(mk(1'b1, OP_BEQ, 1, 1, 32'h100 + 32'(8 * g), 32'h40, 0, 1'b1, 32'h40),
            mk(1'b1, OP_BNE, 1, 1, 32'h104 + 32'(8 * g), 32'h50, 0, 1'b0, 0));
      @(posedge clk);
      @(negedge clk);
    end
    drive_idle();
    check("full_dcnt", 32'(dcnt), 2);
    check("full_upd_valid", 32'(upd_valid), 1);
    check("full_head_pc", upd_pc, 32'h100);
    check("full_mcnt", 32'(mcnt), 32'(exp_m));
    // Push and pop in the same cycle while full: one slot frees, one lane drops.
    ready = 1'b1;
    drive(mk(1'b1, OP_BEQ, 1, 1, 32'h200, 32'h40, 0, 1'b1, 32'h40),
          mk(1'b1, OP_BNE, 1, 1, 32'h204, 32'h50, 0, 1'b0, 0));
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check("fullpop_dcnt", 32'(dcnt), 3);
    for (int k = 1; k < 8; k++) exp_q.push_back(32'h100 + 32'(4 * k));
    exp_q.push_back(32'h200);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(upd_valid), 1);
      check($sformatf("drain_pc_%0d", k), upd_pc, exp_q[k]);
      @(posedge clk);
      @(negedge clk);
    end
    ready = 1'b0;
    check("drain_empty", 32'(upd_valid), 0);

    // Asynchronous reset with queued entries and a pending redirect.
    drive(mk(1'b1, OP_BEQ, 1, 1, 32'h300, 32'h40, 0, 1'b1, 32'h40),
          mk(1'b1, OP_BNE, 1, 1, 32'h304, 32'h50, 0, 1'b0, 0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(1'b1, OP_BEQ, 2, 2, 32'h308, 32'h60, 0, 1'b1, 32'h60),
          mk(1'b1, OP_BNE, 1, 2, 32'h30C, 32'h70, 0, 1'b0, 0));
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    stall = 1'b1;
    exp_m++;
    check("pre_rst_rv", 32'(rv), 1);
    check("pre_rst_rpc", rpc, 32'h70);
    check("pre_rst_mcnt", 32'(mcnt), 32'(exp_m));
    check("pre_rst_upd_valid", 32'(upd_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rv", 32'(rv), 0);
    check("async_rst_kill", 32'(kill), 0);
    check("async_rst_upd_valid", 32'(upd_valid), 0);
    check("async_rst_mcnt", 32'(mcnt), 0);
    check("async_rst_dcnt", 32'(dcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    check("post_rst_upd_valid", 32'(upd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Multi-lane, pipelined successor to the single-lane combinational branch resolver in inst_exec.
- Resolves up to N_LANES control-flow instructions per cycle and compares each result against its front-end prediction.
- Registers one redirect request per cycle for the fetch unit, oldest mispredicting lane wins.
- Queues resolved outcomes in a handshaked FIFO toward the BTB/BHT updater, with saturating performance counters.

Parameters:
N_LANES, 2, number of issue lanes resolved per cycle (1..4); lane 0 is oldest in program order
UPD_DEPTH, 8, predictor-update FIFO depth (power of two, >= N_LANES)
CNT_WIDTH, 16, width of the saturating mispredict and drop counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hold the stage register; no new capture
flush_i  in  1  kill stage-register contents (younger-than-EX flush)
pipe_id_i  in  N_LANES x pipe_id_t  per-lane decoded instruction (valid, op, is_controlflow, default_jump_i/j)
reg0_i  in  N_LANES x 32  rs operand
reg1_i  in  N_LANES x 32  rt operand
pc_i  in  N_LANES x 32  instruction PC
pred_taken_i  in  N_LANES  predicted direction
pred_target_i  in  N_LANES x 32  predicted target
redirect_valid_o  out  1  registered redirect request
redirect_pc_o  out  32  correct next PC
redirect_lane_o  out  clog2(N_LANES)  lane that caused the redirect
kill_mask_o  out  N_LANES  lanes younger than the redirecting lane, to be squashed
upd_valid_o  out  1  update FIFO head valid
upd_ready_i  in  1  updater accepts head
upd_pc_o  out  32  head branch PC
upd_taken_o  out  1  head resolved direction
upd_target_o  out  32  head resolved target
mispredict_cnt_o  out  CNT_WIDTH  saturating count of mispredicts
drop_cnt_o  out  CNT_WIDTH  saturating count of updates lost to a full FIFO

Behaviour:
- Reset (rst_n=0, async): stage register invalid; all outputs 0; FIFO empty (rd_ptr = wr_ptr = 0); both counters 0. Reset mid-operation discards pending redirects and queued updates.
- Per-lane resolution is combinational, using the existing op rules:
  - BLTZ/BLTZAL: taken = reg1[31]
  - BGEZ/BGEZAL: taken = ~reg1[31]
  - BEQ / BNE: taken = equal / ~equal
  - BLEZ: taken = equal | reg1[31]
  - BGTZ: taken = ~equal & ~reg1[31]
  - JAL/JALR: always taken
  - Targets: default_jump_i for conditional branches, default_jump_j for JAL, reg0 for JALR.
- Lane resolved = valid & is_controlflow.
- Mispredict = resolved & (taken != pred_taken | (taken & target != pred_target)).
- Correct PC = taken ? target : pc + 8. Not-taken resumes after the delay slot; 32-bit wrap-around is allowed.
- Stage register:
  - Captures when ~stall_i & ~flush_i.
  - flush_i clears it (priority over stall_i).
  - stall_i holds it unchanged.
- Redirect latency is 1 cycle. redirect_valid_o asserts for exactly one cycle per captured mispredict; it is not repeated while stalled.
- Lowest-index mispredicting lane selects redirect_pc_o and redirect_lane_o.
- kill_mask_o sets every bit above redirect_lane_o; it is 0 when no redirect is asserted.
- Update FIFO push:
  - Each captured resolved lane not killed by an older lane's mispredict is pushed, in lane order, in the capture cycle.
  - Pushes are limited by free space, counting a same-cycle pop.
  - Excess entries are dropped; drop_cnt_o increases by the number dropped.
- Update FIFO pop: on upd_valid_o & upd_ready_i. Simultaneous push and pop when full is legal.
- Pointers are clog2(UPD_DEPTH)+1 bits. Full is MSB differ / LSBs equal; empty is pointers equal.
- Head outputs come straight from storage with no extra latency.
- Counters saturate at all-ones. mispredict_cnt_o increments by 1 per cycle with redirect capture, and is unaffected by flush.

Optional Feature:
BRANCH_LIKELY_EN
- Defined:
  - Adds resolution of BEQL/BNEL/BLEZL/BGTZL/BLTZL/BGEZL with the same taken rules as their base ops.
  - A not-taken likely branch always raises a redirect to pc+8, regardless of prediction, with kill_mask_o also including the delay-slot lane (branch lane + 1) when that lane exists in the same group.
  - It also sets redirect_nullify_o (extra 1-bit output) so the delay slot in the next group is squashed when the branch is in the last lane.
- Undefined: likely ops resolve as not-taken without redirect, and redirect_nullify_o is absent.

Test Plan:
- N_LANES=2, lane0 BEQ with reg0=reg1=5, pred_taken=0, default_jump_i=0x1000, pc=0x400 -> next cycle redirect_valid=1, redirect_pc=0x1000, lane=0, kill_mask=2'b10, mispredict_cnt=1.
- Lane0 BNE correctly predicted not-taken; lane1 JALR reg0=0x8000, pred_target=0x7000 -> redirect_pc=0x8000, lane=1, kill_mask=0, two FIFO entries pushed.
- stall_i held 3 cycles after a mispredict capture -> redirect_valid high exactly 1 cycle; flush_i in the same cycle as valid input -> no redirect, no push.
- upd_ready_i=0, 5 groups of 2 resolved branches, UPD_DEPTH=8 -> FIFO holds 8, drop_cnt=2, upd_valid stays 1; then ready=1 drains in order by PC.
- BLTZ with reg1=0x8000_0000 at pc=0xFFFF_FFF8, pred taken, target correct -> no redirect; same with reg1=0 -> redirect_pc=0x0000_0000 (wrap).
- Assert rst_n=0 mid-stream with 4 queued entries -> upd_valid=0, counters=0, redirect_valid=0 immediately, without waiting for clk.
